// File: rtl/demux_pkg.sv
// demux_pkg: shared widths, depths and pointer-width helper for the buffered demux
package demux_pkg;
  localparam int DATA_W = 32;
  localparam int FIFO_DEPTH = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: synchronous FIFO with registered head output and cleared storage on reset
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_d,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head_d,
  output logic             full
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;
  assign valid   = count != '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign head_d  = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_d;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/demux2_buf.sv
// demux2_buf: steers one input word stream into two independently buffered output ports
module demux2_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_s,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_d,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_d
);
  logic full0, full1, push0, push1;
  assign in_ready = in_s ? !full1 : !full0;
  assign push0    = in_valid && in_ready && !in_s;
  assign push1    = in_valid && in_ready && in_s;
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .push(push0), .push_d(in_d), .pop(out0_ready),
    .valid(out0_valid), .head_d(out0_d), .full(full0)
  );
  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .push(push1), .push_d(in_d), .pop(out1_ready),
    .valid(out1_valid), .head_d(out1_d), .full(full1)
  );
endmodule

// File: tb/tb_demux2_buf.sv
// tb_demux2_buf: directed and random checks of demux2_buf against a queue-based reference
module tb_demux2_buf;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_s;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] in_d, out0_d, out1_d;
  int          checks = 0, errors = 0, pops1 = 0;
  logic [31:0] q0[$], q1[$];
  bit          acc;
  demux2_buf dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_s(in_s),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_d(out0_d),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_d(out1_d)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input bit rst, input bit v, input bit s, input logic [31:0] d, input bit r0, input bit r1);
    bit er, p0, p1;
    reset = rst; in_valid = v; in_s = s; in_d = d; out0_ready = r0; out1_ready = r1;
    #1;
    er = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(er));
    acc = !rst && v && er;
    p0  = !rst && r0 && q0.size() != 0;
    p1  = !rst && r1 && q1.size() != 0;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) begin
        void'(q1.pop_front());
        pops1++;
      end
      if (acc) begin
        if (s) q1.push_back(d);
        else q0.push_back(d);
      end
    end
    #1;
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_d", out0_d, q0[0]);
    else if (rst) chk("out0_d_reset", out0_d, 32'h0);
    if (q1.size() != 0) chk("out1_d", out1_d, q1[0]);
    else if (rst) chk("out1_d_reset", out1_d, 32'h0);
  endtask
  initial begin
    int n;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 32'hAAAA0001, 0, 0);
    chk("first_out0_d", out0_d, 32'hAAAA0001);
    chk("first_out1_valid", 32'(out1_valid), 32'h0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("popped_out0_valid", 32'(out0_valid), 32'h0);
    cycle(0, 1, 0, 32'h10, 0, 0);
    cycle(0, 1, 0, 32'h11, 0, 0);
    cycle(0, 1, 0, 32'h12, 0, 0);
    chk("third_push_blocked", 32'(acc), 32'h0);
    cycle(0, 1, 1, 32'h20, 0, 0);
    chk("other_port_accepts", 32'(acc), 32'h1);
    cycle(0, 1, 0, 32'h12, 1, 0);
    chk("full_push_with_pop_blocked", 32'(acc), 32'h0);
    chk("head_after_pop", out0_d, 32'h11);
    cycle(0, 1, 0, 32'h12, 1, 0);
    chk("retry_push_accepted", 32'(acc), 32'h1);
    chk("head_after_retry", out0_d, 32'h12);
    repeat (3) cycle(0, 0, 0, 0, 1, 1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, i[0], 32'h100 + i, 1, 1);
      n += int'(acc);
    end
    chk("alternate_accepted", 32'(n), 32'd16);
    repeat (2) cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 1, i[0], $urandom, 0, 0);
    chk("both_full0", 32'(out0_valid & out1_valid), 32'h1);
    cycle(1, 1, 0, 32'hDEAD, 1, 1);
    chk("reset_out0_d", out0_d, 32'h0);
    chk("reset_out1_d", out1_d, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("reset_in_ready_s0", 32'(in_ready), 32'h1);
    cycle(0, 0, 1, 0, 0, 0);
    chk("reset_in_ready_s1", 32'(in_ready), 32'h1);
    pops1 = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      cycle(0, 1, 1, $urandom, 0, 1'($urandom_range(0, 1)));
      n += int'(acc);
    end
    chk("port1_pushes", 32'(n), 32'd20);
    for (int c = 0; c < 10 && q1.size() != 0; c++) cycle(0, 0, 1, 0, 0, 1);
    chk("port1_pops", 32'(pops1), 32'd20);
    chk("port1_drained", 32'(out1_valid), 32'h0);
    for (int c = 0; c < 300; c++)
      cycle($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
